// File: rtl/megacart_nvram_io_if.sv
// ----------------------------------------------------------------------------
// megacart_nvram_io_if
//
// Bus bundle for the MegaCart NVRAM mover. It groups two buses:
//   - the MiST user_io SD sector-buffer interface
//     (sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
//      sd_buff_din)
//   - the SDRAM byte port (mem_addr, mem_dout, mem_din, mem_we, mem_req,
//     mem_ack)
//
// Modports:
//   master - the NVRAM mover; drives requests, addresses and write data
//   slave  - the SD firmware and the SDRAM controller
// ----------------------------------------------------------------------------
interface megacart_nvram_io_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    logic [22:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        output mem_addr, mem_dout, mem_we, mem_req,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  mem_din, mem_ack
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  mem_addr, mem_dout, mem_we, mem_req,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output mem_din, mem_ack
    );
endinterface

// File: rtl/megacart_nvram_io.sv
// ----------------------------------------------------------------------------
// megacart_nvram_io
//
// Moves the MegaCart 8 KB NVRAM image between the SD card and SDRAM, one
// 512-byte sector at a time through a local sector buffer. The file is linear;
// SDRAM holds it sparsely at NVRAM_BASE | vic_addr:
//   file 0x0400..0x0FFF -> vic 0x0400..0x0FFF
//   file 0x1800..0x1FFF -> vic 0x9800..0x9FFF
//   everything else is unmapped (skipped on load, FILL_BYTE on save)
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   img_mounted      pulse: image (re)mounted; img_size = 0 means unmounted
//   img_size         mounted image size in bytes
//   save_req         pulse: write NVRAM back to SD (ignored while unmounted)
//   nvram_wr         pulse: VIC wrote NVRAM (autosave build only)
//   busy             high in every non-IDLE state; the core stalls the VIC
//   bus              megacart_nvram_io_if.master: SD sector buffer + SDRAM
//
// Build option: define NVRAM_AUTOSAVE_EN to save automatically after
// AUTOSAVE_DELAY idle clocks following the last nvram_wr.
// ----------------------------------------------------------------------------
module megacart_nvram_io #(
    parameter logic [22:0] NVRAM_BASE     = 23'h400000,
    parameter logic [7:0]  FILL_BYTE      = 8'hFF,
    parameter logic [23:0] AUTOSAVE_DELAY = 24'd8000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       img_mounted,
    input  logic [31:0]                img_size,
    input  logic                       save_req,
    input  logic                       nvram_wr,
    output logic                       busy,
    megacart_nvram_io_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE, LD_REQ, LD_XFER, LD_COPY, SV_COPY, SV_REQ, SV_XFER, NEXT
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  lba;
    logic [8:0]  idx;
    logic        is_save;
    logic        mounted;
    logic        mounted_nxt;
    logic        pending;
    logic        ack_q;
    logic        auto_go;
    logic        start_load;
    logic        start_save;
    logic        copy_step;
    logic        mapped_now;
    logic [15:0] vic_now;
    logic        ack_fall;

    logic [7:0]  sbuf [0:511];
    logic        buf_we;
    logic [8:0]  buf_waddr;
    logic [7:0]  buf_wdata;

    function automatic logic is_mapped(input logic [12:0] f);
        return ((f >= 13'h0400) && (f < 13'h1000)) || (f >= 13'h1800);
    endfunction

    // The upper window lives at 0x9800 in VIC space: same low bits, A15 set.
    function automatic logic [15:0] vic_addr(input logic [12:0] f);
        return {3'b000, f} | (f[12] ? 16'h8000 : 16'h0000);
    endfunction

    assign mapped_now  = is_mapped({lba, idx});
    assign vic_now     = vic_addr({lba, idx});
    assign ack_fall    = ack_q && !bus.sd_ack;
    assign mounted_nxt = img_mounted ? (img_size != 32'd0) : mounted;

    // A mount beats a save arriving in the same cycle; the save stays pending.
    assign start_load = (state == IDLE) && img_mounted && (img_size != 32'd0);
    assign start_save = (state == IDLE) && !start_load && mounted &&
                        (save_req || pending || auto_go);

    assign busy        = (state != IDLE);
    assign bus.sd_rd   = (state == LD_REQ);
    assign bus.sd_wr   = (state == SV_REQ);
    assign bus.sd_lba  = {28'd0, lba};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        copy_step = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = idx;
        buf_wdata = FILL_BYTE;
        case (state)
            IDLE: begin
                if (start_load)      state_nxt = LD_REQ;
                else if (start_save) state_nxt = SV_COPY;
            end
            LD_REQ: if (bus.sd_ack) state_nxt = LD_XFER;
            LD_XFER: begin
                if (bus.sd_buff_wr) begin
                    buf_we    = 1'b1;
                    buf_waddr = bus.sd_buff_addr;
                    buf_wdata = bus.sd_buff_dout;
                end
                if (ack_fall) state_nxt = LD_COPY;
            end
            LD_COPY: begin
                copy_step = !mapped_now || bus.mem_ack;
                if (copy_step && idx == 9'd511) state_nxt = NEXT;
            end
            SV_COPY: begin
                if (!mapped_now) begin
                    buf_we    = 1'b1;
                    copy_step = 1'b1;
                end else if (bus.mem_ack) begin
                    buf_we    = 1'b1;
                    buf_wdata = bus.mem_din;
                    copy_step = 1'b1;
                end
                if (copy_step && idx == 9'd511) state_nxt = SV_REQ;
            end
            SV_REQ:  if (bus.sd_ack) state_nxt = SV_XFER;
            SV_XFER: if (ack_fall)   state_nxt = NEXT;
            NEXT: begin
                if (lba == 4'd15) state_nxt = IDLE;
                else if (is_save) state_nxt = SV_COPY;
                else              state_nxt = LD_REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sector buffer: one write port shared by SD load and SDRAM read-back.
    always_ff @(posedge clk) begin
        if (buf_we) sbuf[buf_waddr] <= buf_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lba             <= 4'd0;
            idx             <= 9'd0;
            is_save         <= 1'b0;
            mounted         <= 1'b0;
            pending         <= 1'b0;
            ack_q           <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= 23'd0;
            bus.mem_dout    <= 8'd0;
            bus.sd_buff_din <= 8'd0;
        end else begin
            ack_q   <= bus.sd_ack;
            mounted <= mounted_nxt;

            if (!mounted_nxt || start_save)
                pending <= 1'b0;
            else if (save_req && (state != IDLE || start_load))
                pending <= 1'b1;

            if (start_load || start_save) begin
                lba     <= 4'd0;
                idx     <= 9'd0;
                is_save <= start_save;
            end
            if (copy_step)
                idx <= idx + 9'd1;
            if (state == NEXT && lba != 4'd15) begin
                lba <= lba + 4'd1;
                idx <= 9'd0;
            end

            // Single outstanding request; mem_req falls the cycle after ack.
            if (bus.mem_req) begin
                if (bus.mem_ack) begin
                    bus.mem_req <= 1'b0;
                    bus.mem_we  <= 1'b0;
                end
            end else if ((state == LD_COPY || state == SV_COPY) && mapped_now) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= (state == LD_COPY);
                bus.mem_addr <= NVRAM_BASE | {7'd0, vic_now};
                bus.mem_dout <= sbuf[idx];
            end

            if (state == SV_XFER)
                bus.sd_buff_din <= sbuf[bus.sd_buff_addr];
        end
    end

`ifdef NVRAM_AUTOSAVE_EN
    logic        dirty;
    logic [23:0] idle_cnt;

    assign auto_go = dirty && (idle_cnt == 24'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty    <= 1'b0;
            idle_cnt <= 24'd0;
        end else if (nvram_wr) begin
            dirty    <= 1'b1;
            idle_cnt <= AUTOSAVE_DELAY;
        end else begin
            // Starting a save snapshots NVRAM; a finished load makes it clean.
            if (start_save || (state == NEXT && lba == 4'd15 && !is_save))
                dirty <= 1'b0;
            if (dirty && state == IDLE && idle_cnt != 24'd0)
                idle_cnt <= idle_cnt - 24'd1;
        end
    end
`else
    logic unused_cfg;

    assign auto_go    = 1'b0;
    assign unused_cfg = ^{nvram_wr, AUTOSAVE_DELAY};
`endif

endmodule
